mixer_arb: RTL and testbench

Frame-level round-robin arbiter that merges the six 9-bit transmit source FIFOs (port0–port3, arp, nic) into one output FIFO without interleaving bytes of different frames. It sits between the per-source queues and the tx mixing queue. It grants one source for a whole frame, forwards words at one word per cycle under output backpressure, and recovers from sources that stall mid-frame.

---
 rtl/mixer_arb.sv | 174 +++++++++++++++++
 tb/tb_mixer_arb.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mixer_arb.sv
// Frame-level round-robin arbiter merging six FWFT byte sources into one output FIFO.
// A granted source owns the output until its EOF word, or until the stall watchdog aborts the frame.
module mixer_arb #(
    parameter int TIMEOUT = 1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [8:0]  port0_dout,
    input  logic        port0_empty,
    output logic        port0_rd_en,
    input  logic [8:0]  port1_dout,
    input  logic        port1_empty,
    output logic        port1_rd_en,
    input  logic [8:0]  port2_dout,
    input  logic        port2_empty,
    output logic        port2_rd_en,
    input  logic [8:0]  port3_dout,
    input  logic        port3_empty,
    output logic        port3_rd_en,
    input  logic [8:0]  arp_dout,
    input  logic        arp_empty,
    output logic        arp_rd_en,
    input  logic [8:0]  nic_dout,
    input  logic        nic_empty,
    output logic        nic_rd_en,
    output logic [8:0]  din,
    input  logic        full,
    output logic        wr_en,
    output logic        busy,
    output logic [15:0] abort_count
);

    localparam int            NSRC   = 6;
    localparam int            TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit            TMO_EN = (TIMEOUT > 0);
    localparam logic [TW-1:0] TLAST  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_grant;
    logic [2:0]      r_last;
    logic [TW-1:0]   r_timer;
    logic [8:0]      r_din;
    logic            r_wr_en;
    logic [15:0]     r_abort_cnt;

    // Sources padded to 8 entries so a 3-bit grant index is always in range.
    logic [7:0][8:0] w_dout;
    logic [7:0]      w_empty;
    logic [7:0]      w_req;
    logic [7:0]      w_rd_en;
    logic [8:0]      w_head;
    logic            w_src_empty;
    logic            w_pop;
    logic            w_eof;
    logic            w_starve;
    logic            w_tmo;
    logic            w_any;
    logic [2:0]      w_win;
    logic [2:0]      w_idx;

    assign w_dout  = {9'h000, 9'h000, nic_dout, arp_dout,
                      port3_dout, port2_dout, port1_dout, port0_dout};
    assign w_empty = {2'b11, nic_empty, arp_empty,
                      port3_empty, port2_empty, port1_empty, port0_empty};
    assign w_req   = ~w_empty;

    function automatic logic [2:0] f_next(input logic [2:0] a);
        return (a == 3'(NSRC - 1)) ? 3'd0 : a + 3'd1;
    endfunction

    // Rotating priority: walk last+1, last+2, ... and keep the first requester.
    always_comb begin
        w_any = 1'b0;
        w_win = r_last;
        w_idx = r_last;
        for (int k = 0; k < NSRC; k++) begin
            w_idx = f_next(w_idx);
            if (!w_any && w_req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_head      = w_dout[r_grant];
    assign w_src_empty = w_empty[r_grant];
    assign w_pop       = (r_state == S_XFER) && !w_src_empty && !full;
    assign w_eof       = w_pop && w_head[8];
    assign w_starve    = (r_state == S_XFER) && w_src_empty && !full;
    assign w_tmo       = TMO_EN && w_starve && (r_timer == TLAST);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_XFER;
            S_XFER: begin
                if (w_eof)      w_state_nxt = S_IDLE;
                else if (w_tmo) w_state_nxt = S_ABORT;
            end
            S_ABORT: if (!full) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_en = '0;
        if (w_pop) w_rd_en[r_grant] = 1'b1;
    end

    assign busy        = (r_state != S_IDLE);
    assign port0_rd_en = w_rd_en[0];
    assign port1_rd_en = w_rd_en[1];
    assign port2_rd_en = w_rd_en[2];
    assign port3_rd_en = w_rd_en[3];
    assign arp_rd_en   = w_rd_en[4];
    assign nic_rd_en   = w_rd_en[5];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_grant     <= 3'd0;
            r_last      <= 3'(NSRC - 1);
            r_timer     <= '0;
            r_din       <= 9'h000;
            r_wr_en     <= 1'b0;
            r_abort_cnt <= 16'h0000;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_win;
                        r_last  <= w_win;
                        r_timer <= '0;
                    end
                end
                S_XFER: begin
                    if (w_pop) begin
                        r_din   <= w_head;
                        r_wr_en <= 1'b1;
                        r_timer <= '0;
                    end else if (w_starve && TMO_EN) begin
                        r_timer <= w_tmo ? '0 : r_timer + 1'b1;
                    end
                end
                S_ABORT: begin
                    // Bare EOF marker closes the truncated frame downstream.
                    if (!full) begin
                        r_din   <= 9'h100;
                        r_wr_en <= 1'b1;
                        if (r_abort_cnt != 16'hFFFF) r_abort_cnt <= r_abort_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign din         = r_din;
    assign wr_en       = r_wr_en;
    assign abort_count = r_abort_cnt;

endmodule

// File: tb/tb_mixer_arb.sv
// Bench for mixer_arb: queue-backed FWFT sources, a frame-level round-robin reference
// model, and directed scenarios for latency, backpressure, watchdog and reset.
module tb_mixer_arb;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  dout [6];
    logic        empty_s [6];
    logic [5:0]  rd;
    logic [8:0]  din;
    logic        full_i = 1'b0;
    logic        wr_en;
    logic        busy;
    logic [15:0] abort_count;

    mixer_arb #(.TIMEOUT(TO)) dut (
        .sys_clk(clk), .sys_rst(rst),
        .port0_dout(dout[0]), .port0_empty(empty_s[0]), .port0_rd_en(rd[0]),
        .port1_dout(dout[1]), .port1_empty(empty_s[1]), .port1_rd_en(rd[1]),
        .port2_dout(dout[2]), .port2_empty(empty_s[2]), .port2_rd_en(rd[2]),
        .port3_dout(dout[3]), .port3_empty(empty_s[3]), .port3_rd_en(rd[3]),
        .arp_dout(dout[4]),   .arp_empty(empty_s[4]),   .arp_rd_en(rd[4]),
        .nic_dout(dout[5]),   .nic_empty(empty_s[5]),   .nic_rd_en(rd[5]),
        .din(din), .full(full_i), .wr_en(wr_en), .busy(busy), .abort_count(abort_count)
    );

    always #5 clk = ~clk;

    logic [8:0] q       [6][$];
    logic [8:0] exp_src [6][$];
    logic [8:0] exp_out [$];
    logic [8:0] out_q   [$];
    int         out_t   [$];
    int         cyc_n = 0, total = 0, bad = 0;
    int         m_last = 5, m_aborts = 0, bp_mode = 0;
    logic [5:0] rd_cap = '0;

    // Source FIFOs and output monitor.
    always @(negedge clk) begin
        cyc_n++;
        for (int i = 0; i < 6; i++) begin
            empty_s[i] = (q[i].size() == 0);
            dout[i]    = (q[i].size() != 0) ? q[i][0] : 9'h000;
        end
        case (bp_mode)
            1:       full_i = ~full_i;
            2:       full_i = ($urandom_range(0, 2) == 0);
            default: full_i = 1'b0;
        endcase
        #1;
        rd_cap = rd;
        if (wr_en === 1'b1) begin
            out_q.push_back(din);
            out_t.push_back(cyc_n);
        end
    end

    always @(posedge clk)
        for (int i = 0; i < 6; i++)
            if (rd_cap[i] && q[i].size() != 0) void'(q[i].pop_front());

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < 6; i++) if (q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_word(input int s, input logic [8:0] w);
        q[s].push_back(w);
        exp_src[s].push_back(w);
    endtask

    // High nibble of every byte carries the source index.
    task automatic push_frame(input int s, input int len);
        for (int k = 0; k < len; k++)
            push_word(s, {(k == len - 1), 4'(s), 4'($urandom_range(0, 15))});
    endtask

    // Whole frames in rotating order, starting after the last granted source.
    task automatic model_run();
        int  sel;
        bit  found;
        logic [8:0] w;
        while (1) begin
            found = 0;
            sel   = 0;
            for (int k = 1; k <= 6; k++)
                if (!found && exp_src[(m_last + k) % 6].size() != 0) begin
                    found = 1;
                    sel   = (m_last + k) % 6;
                end
            if (!found) break;
            do begin
                w = exp_src[sel].pop_front();
                exp_out.push_back(w);
            end while (!w[8] && exp_src[sel].size() != 0);
            m_last = sel;
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (all_empty() && !busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic clear_obs();
        out_q.delete();
        out_t.delete();
        exp_out.delete();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bp_mode = 0;
        for (int i = 0; i < 6; i++) begin
            q[i].delete();
            exp_src[i].delete();
        end
        cyc();
        cyc();
        rst      = 1'b0;
        m_last   = 5;
        m_aborts = 0;
        clear_obs();
    endtask

    task automatic test_reset();
        do_reset();
        cyc();
        total++; if (din !== 9'h000) begin bad++; $display("FAIL reset_din got=%h exp=000", din); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (abort_count !== 16'h0) begin bad++; $display("FAIL reset_abort got=%0d exp=0", abort_count); end
        total++; if (rd !== 6'b0) begin bad++; $display("FAIL reset_rd got=%b exp=000000", rd); end
    endtask

    task automatic test_single_frame();
        int         e_wr   [7] = '{0, 0, 1, 1, 1, 1, 0};
        int         e_busy [7] = '{0, 1, 1, 1, 1, 0, 0};
        int         e_rd   [7] = '{0, 1, 1, 1, 1, 0, 0};
        logic [8:0] e_din  [7] = '{9'h000, 9'h000, 9'h011, 9'h022, 9'h033, 9'h1FF, 9'h1FF};
        clear_obs();
        push_word(2, 9'h011); push_word(2, 9'h022); push_word(2, 9'h033); push_word(2, 9'h1FF);
        for (int j = 0; j < 7; j++) begin
            cyc();
            total++;
            if (wr_en !== 1'(e_wr[j])) begin bad++; $display("FAIL single_wr[%0d] got=%b exp=%0d", j, wr_en, e_wr[j]); end
            total++;
            if (busy !== 1'(e_busy[j])) begin bad++; $display("FAIL single_busy[%0d] got=%b exp=%0d", j, busy, e_busy[j]); end
            total++;
            if (rd !== (e_rd[j] != 0 ? 6'b000100 : 6'b000000)) begin
                bad++; $display("FAIL single_rd[%0d] got=%b exp_port2=%0d", j, rd, e_rd[j]);
            end
            if (e_wr[j] != 0) begin
                total++;
                if (din !== e_din[j]) begin bad++; $display("FAIL single_din[%0d] got=%h exp=%h", j, din, e_din[j]); end
            end
        end
        model_run();
    endtask

    task automatic test_round_robin();
        bit ok;
        int srcs [$];
        do_reset();
        for (int s = 0; s < 6; s++) push_frame(s, 2);
        model_run();
        wait_done(200, ok);
        cyc();
        total++; if (!ok) begin bad++; $display("FAIL rr_timeout got=busy exp=idle"); end
        total++; if (out_q.size() != 12) begin bad++; $display("FAIL rr_len got=%0d exp=12", out_q.size()); end
        for (int i = 0; i < exp_out.size() && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_out[i]) begin bad++; $display("FAIL rr_word[%0d] got=%h exp=%h", i, out_q[i], exp_out[i]); end
        end
        foreach (out_q[i]) if (out_q[i][8]) srcs.push_back(int'(out_q[i][7:4]));
        for (int i = 0; i < 6 && i < srcs.size(); i++) begin
            total++;
            if (srcs[i] != i) begin bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, srcs[i], i); end
        end
        for (int i = 1; i < out_t.size(); i++) begin
            total++;
            if (out_t[i] - out_t[i-1] != ((i % 2 == 0) ? 2 : 1)) begin
                bad++; $display("FAIL rr_gap[%0d] got=%0d exp=%0d", i, out_t[i] - out_t[i-1], (i % 2 == 0) ? 2 : 1);
            end
        end
    endtask

    task automatic test_rotation();
        bit ok;
        int srcs [$];
        int e_src [6] = '{1, 5, 1, 5, 1, 5};
        clear_obs();
        bp_mode = 2;
        for (int f = 0; f < 3; f++) begin
            push_frame(1, $urandom_range(1, 5));
            push_frame(5, $urandom_range(1, 5));
        end
        model_run();
        wait_done(400, ok);
        bp_mode = 0;
        cyc();
        total++; if (!ok) begin bad++; $display("FAIL rot_timeout got=busy exp=idle"); end
        total++; if (out_q.size() != exp_out.size()) begin bad++; $display("FAIL rot_len got=%0d exp=%0d", out_q.size(), exp_out.size()); end
        for (int i = 0; i < exp_out.size() && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_out[i]) begin bad++; $display("FAIL rot_word[%0d] got=%h exp=%h", i, out_q[i], exp_out[i]); end
        end
        foreach (out_q[i]) if (out_q[i][8]) srcs.push_back(int'(out_q[i][7:4]));
        total++; if (srcs.size() != 6) begin bad++; $display("FAIL rot_frames got=%0d exp=6", srcs.size()); end
        for (int i = 0; i < 6 && i < srcs.size(); i++) begin
            total++;
            if (srcs[i] != e_src[i]) begin bad++; $display("FAIL rot_src[%0d] got=%0d exp=%0d", i, srcs[i], e_src[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit prev_rd;
        clear_obs();
        push_frame(3, 10);
        model_run();
        bp_mode = 1;
        prev_rd = 1'b0;
        ok      = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            total++;
            if (full_i && rd != 6'b0) begin bad++; $display("FAIL bp_rd_while_full got=%b exp=000000", rd); end
            total++;
            if (wr_en !== prev_rd) begin bad++; $display("FAIL bp_wr_follows_pop got=%b exp=%b", wr_en, prev_rd); end
            prev_rd = |rd;
            if (all_empty() && !busy) begin ok = 1; break; end
        end
        bp_mode = 0;
        cyc();
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=busy exp=idle"); end
        total++; if (out_q.size() != 10) begin bad++; $display("FAIL bp_len got=%0d exp=10", out_q.size()); end
        for (int i = 0; i < exp_out.size() && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_out[i]) begin bad++; $display("FAIL bp_word[%0d] got=%h exp=%h", i, out_q[i], exp_out[i]); end
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int it = 0; it < 6; it++) begin
            clear_obs();
            for (int s = 0; s < 6; s++)
                if ($urandom_range(0, 1) == 1)
                    for (int f = 0; f < int'($urandom_range(1, 3)); f++) push_frame(s, $urandom_range(1, 5));
            model_run();
            bp_mode = 2;
            wait_done(1500, ok);
            bp_mode = 0;
            cyc();
            total++; if (!ok) begin bad++; $display("FAIL rand%0d_timeout got=busy exp=idle", it); end
            total++;
            if (out_q.size() != exp_out.size()) begin
                bad++; $display("FAIL rand%0d_len got=%0d exp=%0d", it, out_q.size(), exp_out.size());
            end
            for (int i = 0; i < exp_out.size() && i < out_q.size(); i++) begin
                total++;
                if (out_q[i] !== exp_out[i]) begin bad++; $display("FAIL rand%0d_word[%0d] got=%h exp=%h", it, i, out_q[i], exp_out[i]); end
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [8:0] e_w [4] = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h100};
        clear_obs();
        q[3].push_back(9'h0A0); q[3].push_back(9'h0A1); q[3].push_back(9'h0A2);
        ok = 0;
        for (int i = 0; i < 80; i++) begin
            cyc();
            if (out_q.size() >= 4) begin ok = 1; break; end
        end
        m_aborts++;
        total++; if (!ok) begin bad++; $display("FAIL tmo_no_abort got=%0d exp=4", out_q.size()); end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== e_w[i]) begin bad++; $display("FAIL tmo_word[%0d] got=%h exp=%h", i, out_q[i], e_w[i]); end
        end
        if (out_t.size() >= 4) begin
            total++;
            if (out_t[3] - out_t[2] != TO + 1) begin bad++; $display("FAIL tmo_delay got=%0d exp=%0d", out_t[3] - out_t[2], TO + 1); end
        end
        total++; if (abort_count !== 16'(m_aborts)) begin bad++; $display("FAIL tmo_count got=%0d exp=%0d", abort_count, m_aborts); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy got=%b exp=0", busy); end
        m_last = 3;
        clear_obs();
        push_frame(0, 2);
        push_frame(4, 3);
        model_run();
        wait_done(200, ok);
        cyc();
        total++; if (!ok) begin bad++; $display("FAIL tmo_resume_timeout got=busy exp=idle"); end
        total++;
        if (out_q.size() == 0 || out_q[0][7:4] !== 4'd4) begin
            bad++; $display("FAIL tmo_resume_src got=%h exp_src=4", (out_q.size() != 0) ? out_q[0] : 9'h000);
        end
        for (int i = 0; i < exp_out.size() && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_out[i]) begin bad++; $display("FAIL tmo_resume_word[%0d] got=%h exp=%h", i, out_q[i], exp_out[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_obs();
        for (int k = 0; k < 6; k++) q[0].push_back({(k == 5), 8'(8'h50 + k)});
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (out_q.size() >= 3) begin ok = 1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL rmid_no_start got=%0d exp=3", out_q.size()); end
        rst = 1'b1;
        cyc();
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rmid_wr_en got=%b exp=0", wr_en); end
        total++; if (din !== 9'h000) begin bad++; $display("FAIL rmid_din got=%h exp=000", din); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        total++; if (abort_count !== 16'h0) begin bad++; $display("FAIL rmid_abort got=%0d exp=0", abort_count); end
        total++; if (rd !== 6'b0) begin bad++; $display("FAIL rmid_rd got=%b exp=000000", rd); end
        rst      = 1'b0;
        m_last   = 5;
        m_aborts = 0;
        clear_obs();
        // The word in flight at the reset edge is popped and lost; w4,w5 remain.
        exp_src[0].push_back(9'h054);
        exp_src[0].push_back(9'h155);
        push_frame(1, 2);
        model_run();
        wait_done(200, ok);
        cyc();
        total++; if (!ok) begin bad++; $display("FAIL rmid_timeout got=busy exp=idle"); end
        total++; if (out_q.size() != exp_out.size()) begin bad++; $display("FAIL rmid_len got=%0d exp=%0d", out_q.size(), exp_out.size()); end
        for (int i = 0; i < exp_out.size() && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_out[i]) begin bad++; $display("FAIL rmid_word[%0d] got=%h exp=%h", i, out_q[i], exp_out[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            empty_s[i] = 1'b1;
            dout[i]    = 9'h000;
        end
        test_reset();
        test_single_frame();
        test_round_robin();
        test_rotation();
        test_backpressure();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
